// File: rtl/pow5_sum_pkg.sv
// Shared types and constants for the x^5 frame-sum accumulator.
package pow5_sum_pkg;

    typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;

    // Sample counter width: covers 0..256 samples per frame.
    localparam int CNT_WIDTH = 9;

    // Default build widths.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N_SAMPLES  = 4;
    localparam int DEF_ACC_WIDTH  = 48;

endpackage

// File: rtl/pow5_sum_out_slot.sv
// One-entry valid/ready output slot for completed frame sums.
// A load is taken when the slot is empty or is being emptied by the handshake
// in the same cycle; otherwise the load is dropped and overflow_o latches.
module pow5_sum_out_slot
    import pow5_sum_pkg::*;
#(
    parameter int SUM_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [SUM_WIDTH-1:0] load_sum_i,
    input  logic [CNT_WIDTH-1:0] load_cnt_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [SUM_WIDTH-1:0] sum_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 overflow_o
);

    logic slot_free;
    logic drop;

    // Slot can accept a new sum if empty or draining this cycle.
    always_comb begin
        slot_free = !valid_o || ready_i;
        drop      = load_i && !slot_free;
    end

    // Slot register: refill, drain, or hold; sticky overflow on a dropped load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            sum_o      <= '0;
            cnt_o      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (load_i && slot_free) begin
                valid_o <= 1'b1;
                sum_o   <= load_sum_i;
                cnt_o   <= load_cnt_i;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (drop)
                overflow_o <= 1'b1;
        end
    end

endmodule

// File: rtl/pow5_sum_accumulator.sv
// Frame accumulator for the x^5 result stream: sums N_SAMPLES valid samples
// (or fewer on flush_i) and hands each frame sum to a one-entry output slot.
// Build option: define POW5_SUM_SATURATE_EN to saturate the accumulator at
// all-ones instead of wrapping.
module pow5_sum_accumulator
    import pow5_sum_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_SAMPLES  = DEF_N_SAMPLES,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pow_valid_i,
    input  logic [5*DATA_WIDTH-1:0] pow_data_i,
    input  logic                    flush_i,
    output logic                    sum_valid_o,
    input  logic                    sum_ready_i,
    output logic [ACC_WIDTH-1:0]    sum_o,
    output logic [CNT_WIDTH-1:0]    sum_cnt_o,
    output logic                    overflow_o
);

    localparam logic [CNT_WIDTH-1:0] FRAME_LEN = CNT_WIDTH'(N_SAMPLES);

    acc_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [ACC_WIDTH-1:0]   acc_base;
    logic [ACC_WIDTH-1:0]   acc_add;
    logic [ACC_WIDTH-1:0]   acc_eff;
    logic [CNT_WIDTH-1:0]   cnt_eff;
    logic                   close;

`ifdef POW5_SUM_SATURATE_EN
    logic [ACC_WIDTH:0]     acc_wide;

    // Saturating add: clamp to all-ones on carry-out; all-ones then stays put.
    always_comb begin
        acc_base = (state_q == ACC_RUN) ? acc_q : '0;
        acc_wide = {1'b0, acc_base} + {1'b0, ACC_WIDTH'(pow_data_i)};
        acc_add  = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];
    end
`else
    // Wrapping add modulo 2^ACC_WIDTH; IDLE starts a fresh frame from zero.
    always_comb begin
        acc_base = (state_q == ACC_RUN) ? acc_q : '0;
        acc_add  = acc_base + ACC_WIDTH'(pow_data_i);
    end
`endif

    // Frame contents as of this edge, with any same-cycle sample included.
    always_comb begin
        acc_eff = pow_valid_i ? acc_add : acc_base;
        cnt_eff = pow_valid_i ? cnt_q + 1'b1 : cnt_q;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= ACC_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: any close returns to IDLE, a sample otherwise opens RUN.
    always_comb begin
        state_d = state_q;
        if (close)
            state_d = ACC_IDLE;
        else if (pow_valid_i)
            state_d = ACC_RUN;
    end

    // FSM output: close on a full frame, or on flush with at least one sample.
    always_comb begin
        close = (pow_valid_i && (cnt_eff == FRAME_LEN)) ||
                (flush_i && (cnt_eff != '0));
    end

    // Accumulator and sample counter; cleared when a frame closes.
    always_ff @(posedge clk_i) begin
        if (rst_i || close) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (pow_valid_i) begin
            acc_q <= acc_add;
            cnt_q <= cnt_eff;
        end
    end

    pow5_sum_out_slot #(
        .SUM_WIDTH (ACC_WIDTH)
    ) u_slot (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (close),
        .load_sum_i (acc_eff),
        .load_cnt_i (cnt_eff),
        .ready_i    (sum_ready_i),
        .valid_o    (sum_valid_o),
        .sum_o      (sum_o),
        .cnt_o      (sum_cnt_o),
        .overflow_o (overflow_o)
    );

endmodule
